// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS registers on a valid/ready bus, byte FIFO, 8N1 serializer.
// Define UART_MMIO_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_mmio_tx #(
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0040
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        txd,
  output logic        tx_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0] BAUD_INIT   = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_MMIO_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic          mem_ready_q, push_q;
  logic [7:0]    push_data_q;
  logic [31:0]   rdata_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q, tx_busy_q;
`ifdef UART_MMIO_TX_PARITY_EN
  logic          parity_q;
`endif

  logic        sel_data_c, sel_status_c, hit_c, is_read_c, want_push_c;
  logic        full_c, empty_c, accept_c, ack_c, baud_done_c, pop_c, idle_next_c;
  logic [31:0] status_c;
  logic        unused_c;

  assign sel_data_c   = (mem_addr == BASE_ADDR);
  assign sel_status_c = (mem_addr == STATUS_ADDR);
  assign hit_c        = mem_valid & ~mem_instr & (sel_data_c | sel_status_c);
  assign is_read_c    = (mem_wstrb == 4'b0000);
  assign want_push_c  = sel_data_c & mem_wstrb[0];
  assign full_c       = (count_q == CW'(FIFO_DEPTH));
  assign empty_c      = (count_q == '0);
  assign accept_c     = ~want_push_c | ~full_c;
  assign ack_c        = hit_c & ~mem_ready_q & accept_c;
  assign status_c     = {16'h0000, 8'(count_q), 5'b00000, tx_busy_q, empty_c, full_c};
  assign baud_done_c  = (baud_q == '0);
  // The serializer takes the head entry when idle or at the very end of a stop bit.
  assign pop_c        = ~empty_c & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_done_c));
  assign idle_next_c  = ~pop_c & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_done_c));
  assign count_d      = count_q + CW'(push_q) - CW'(pop_c);
  assign unused_c     = ^mem_wdata[31:8];

  assign mem_ready = mem_ready_q;
  assign mem_rdata = rdata_q;
  assign txd       = txd_q;
  assign tx_busy   = tx_busy_q;

  // Bus responder: the push is latched with the ack and lands on the edge ending the ready cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      mem_ready_q <= ack_c;
      rdata_q     <= (ack_c & is_read_c & sel_status_c) ? status_c : 32'h0;
      push_q      <= ack_c & want_push_c;
      push_data_q <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_q) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) fifo_q[wptr_q] <= push_data_q;
  end

  // Serializer FSM; txd is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
`ifdef UART_MMIO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_busy_q <= (count_d != '0) | ~idle_next_c;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop_c) begin
            state_q <= S_START;
            shift_q <= fifo_q[rptr_q];
`ifdef UART_MMIO_TX_PARITY_EN
            parity_q <= ^fifo_q[rptr_q];
`endif
            baud_q  <= BAUD_INIT;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done_c) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
            baud_q    <= BAUD_INIT;
            txd_q     <= shift_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_done_c) begin
            baud_q <= BAUD_INIT;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_MMIO_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef UART_MMIO_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done_c) begin
            state_q <= S_STOP;
            baud_q  <= BAUD_INIT;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done_c) begin
            if (pop_c) begin
              state_q <= S_START;
              shift_q <= fifo_q[rptr_q];
`ifdef UART_MMIO_TX_PARITY_EN
              parity_q <= ^fifo_q[rptr_q];
`endif
              baud_q  <= BAUD_INIT;
              txd_q   <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
